// File: rtl/inst_fetcher_pkg.sv
// Fetch-stage shared definitions: opcode constants, FSM states, queue entry
// layout and the static next-PC predictor used by the fetcher.
package inst_fetcher_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    // JAL is always taken; branches and JALR fall through and are fixed by the RoB.
    function automatic logic predict_taken(input logic [6:0] opcode);
        logic taken;
        case (opcode)
            OPC_JAL:              taken = 1'b1;
            OPC_BRANCH, OPC_JALR: taken = 1'b0;
            default:              taken = 1'b0;
        endcase
        return taken;
    endfunction

    // 21-bit J-type immediate, sign-extended to 32 bits.
    function automatic logic [31:0] jal_offset(input logic [31:0] word);
        return {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc,
                                                  input logic [31:0] word);
        return predict_taken(word[6:0]) ? pc + jal_offset(word) : pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Fetcher bus bundle: instruction-memory request/response and decoder handshake.
interface inst_fetcher_if;

    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        issue_ready;
    logic        fetch_ready;
    logic [31:0] inst;
    logic [31:0] pc;

    modport master (
        output mem_req_valid, mem_req_addr, fetch_ready, inst, pc,
        input  mem_resp_valid, mem_resp_data, issue_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, fetch_ready, inst, pc,
        output mem_resp_valid, mem_resp_data, issue_ready
    );

endinterface

// File: rtl/inst_queue.sv
// Circular FIFO of fetched {inst, pc} entries; clear wins over push/pop.
module inst_queue
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    fetch_entry_t     entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W:0]   count;

    // Pointer/count bookkeeping and entry storage; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                entries[tail_ptr] <= push_data;
                tail_ptr          <= tail_ptr + 1'b1;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    assign head  = entries[head_ptr];
    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch front end: one outstanding memory read, fetched words
// queued with their PC, static JAL prediction and RoB flush redirect.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PTR_W    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic [31:0] flush_pc,
    inst_fetcher_if.master bus
);

    fetch_state_e state, state_next;
    logic [31:0]  fetch_pc, fetch_pc_next;
    logic         req_valid, req_valid_next;
    logic [31:0]  req_addr, req_addr_next;

    logic         q_push, q_pop, q_clear;
    logic         q_full, q_empty;
    fetch_entry_t q_push_data, q_head;

    assign q_push_data = '{inst: bus.mem_resp_data, pc: req_addr};

    inst_queue #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_queue (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .push      (q_push),
        .pop       (q_pop),
        .clear     (q_clear),
        .push_data (q_push_data),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    // State, fetch PC and request registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= ST_IDLE;
            fetch_pc  <= RESET_PC;
            req_valid <= 1'b0;
            req_addr  <= '0;
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            req_valid <= req_valid_next;
            req_addr  <= req_addr_next;
        end
    end

    // Next-state, request and queue control; everything holds while rdy_in is low.
    always_comb begin
        state_next     = state;
        fetch_pc_next  = fetch_pc;
        req_valid_next = req_valid;
        req_addr_next  = req_addr;
        q_push         = 1'b0;
        q_pop          = 1'b0;
        q_clear        = 1'b0;

        if (rdy_in) begin
            if (flush_in) begin
                // Redirect: any in-flight read must still complete, but its data is discarded.
                q_clear       = 1'b1;
                fetch_pc_next = flush_pc;
                case (state)
                    ST_WAIT, ST_DROP: begin
                        if (bus.mem_resp_valid) begin
                            state_next     = ST_IDLE;
                            req_valid_next = 1'b0;
                        end else begin
                            state_next = ST_DROP;
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end else begin
                q_pop = bus.issue_ready & ~q_empty;
                case (state)
                    ST_IDLE: begin
                        if (!q_full) begin
                            state_next     = ST_WAIT;
                            req_valid_next = 1'b1;
                            req_addr_next  = fetch_pc;
                        end
                    end
                    ST_WAIT: begin
                        if (bus.mem_resp_valid) begin
                            q_push         = 1'b1;
                            fetch_pc_next  = next_fetch_pc(req_addr, bus.mem_resp_data);
                            state_next     = ST_IDLE;
                            req_valid_next = 1'b0;
                        end
                    end
                    ST_DROP: begin
                        if (bus.mem_resp_valid) begin
                            state_next     = ST_IDLE;
                            req_valid_next = 1'b0;
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end
    end

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = req_addr;
    assign bus.fetch_ready   = ~q_empty;
    assign bus.inst          = q_head.inst;
    assign bus.pc            = q_head.pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_inst_fetcher;

    localparam int unsigned DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_in;
    logic [31:0] flush_pc;

    inst_fetcher_if bus();

    inst_fetcher #(
        .DEPTH    (DEPTH),
        .PTR_W    (2),
        .RESET_PC (32'h0)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .flush_pc (flush_pc),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    // memory responder state
    int unsigned lat;
    int unsigned wait_cnt;
    bit          rdy_prev;
    bit          rand_mode;
    logic [31:0] prog [logic [31:0]];

    // reference model state
    logic [63:0] mq [$];
    logic [31:0] m_fpc;
    logic [31:0] m_addr;
    bit          m_req;
    bit          m_stale;

    function automatic logic [31:0] ref_next_pc(input logic [31:0] pc, input logic [31:0] w);
        int off;
        if (w[6:0] != 7'h6F) return pc + 32'd4;
        off = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096;
        if (w[31]) off = off - (1 << 20);
        return pc + 32'(off);
    endfunction

    task automatic model_step(input bit a_rst, input bit a_rdy, input bit a_flush,
                              input logic [31:0] a_fpc, input bit a_issue,
                              input bit a_resp, input logic [31:0] a_data);
        bit do_pop;
        if (!a_rst) begin
            mq.delete();
            m_fpc = 32'h0; m_addr = 32'h0; m_req = 0; m_stale = 0;
            return;
        end
        if (!a_rdy) return;
        if (a_flush) begin
            mq.delete();
            m_fpc = a_fpc;
            if (m_req) begin
                if (a_resp) begin m_req = 0; m_stale = 0; end
                else m_stale = 1;
            end
            return;
        end
        do_pop = a_issue && (mq.size() > 0);
        if (m_req) begin
            if (a_resp) begin
                m_req = 0;
                if (!m_stale) begin
                    mq.push_back({a_data, m_addr});
                    m_fpc = ref_next_pc(m_addr, a_data);
                end
                m_stale = 0;
            end
        end else if (mq.size() < DEPTH) begin
            m_req  = 1;
            m_addr = m_fpc;
        end
        if (do_pop) void'(mq.pop_front());
    endtask

    // Memory side: serves the current request after lat extra cycles, holds the
    // response while the pipeline is frozen.
    task automatic mem_drive();
        logic [31:0] w;
        if (bus.mem_resp_valid && !rdy_prev) return;
        bus.mem_resp_valid = 1'b0;
        if (bus.mem_req_valid) begin
            if (wait_cnt >= lat) begin
                wait_cnt = 0;
                if (prog.exists(bus.mem_req_addr)) w = prog[bus.mem_req_addr];
                else if (rand_mode) begin
                    w = $urandom;
                    if ($urandom_range(0, 3) == 0) w[6:0] = 7'h6F;
                end else w = 32'h0000_0013;
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = w;
            end else wait_cnt++;
        end else wait_cnt = 0;
    endtask

    // One clock: inputs are applied between negedges, outputs observed at negedge.
    task automatic cycle();
        bit a_rst, a_rdy, a_flush, a_issue, a_resp;
        logic [31:0] a_fpc, a_data;
        mem_drive();
        a_rst = rst_n_in; a_rdy = rdy_in; a_flush = flush_in; a_fpc = flush_pc;
        a_issue = bus.issue_ready; a_resp = bus.mem_resp_valid; a_data = bus.mem_resp_data;
        @(posedge clk_in);
        model_step(a_rst, a_rdy, a_flush, a_fpc, a_issue, a_resp, a_data);
        rdy_prev = a_rdy;
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; flush_pc = 32'h0;
        bus.issue_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 32'h0;
        lat = 0; wait_cnt = 0; rdy_prev = 1'b1; rand_mode = 1'b0;
        prog.delete();
        repeat (3) cycle();
        rst_n_in = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.fetch_ready !== 1'b0) begin n_errors++; $display("FAIL reset_fetch_ready: got %b expected 0", bus.fetch_ready); end
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid: got %b expected 0", bus.mem_req_valid); end
        n_checks++; if (bus.mem_req_addr !== 32'h0) begin n_errors++; $display("FAIL reset_req_addr: got %h expected 0", bus.mem_req_addr); end
        n_checks++; if ({bus.inst, bus.pc} !== 64'h0) begin n_errors++; $display("FAIL reset_head: got %h/%h expected 0/0", bus.inst, bus.pc); end
        cycle();
        n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0) begin n_errors++; $display("FAIL reset_first_req: got %b@%h expected 1@0", bus.mem_req_valid, bus.mem_req_addr); end
        n_checks++; if (bus.fetch_ready !== 1'b0) begin n_errors++; $display("FAIL reset_first_fr: got %b expected 0", bus.fetch_ready); end
    endtask

    task automatic test_sequential();
        logic [31:0] pcs [4];
        logic [31:0] insts [4];
        int got = 0;
        do_reset();
        bus.issue_ready = 1'b1;
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (bus.fetch_ready) begin pcs[got] = bus.pc; insts[got] = bus.inst; got++; end
            cycle();
        end
        n_checks++; if (got != 4) begin n_errors++; $display("FAIL seq_count: got %0d pops expected 4", got); end
        for (int k = 0; k < got; k++) begin
            n_checks++;
            if (pcs[k] !== 32'(4 * k) || insts[k] !== 32'h13) begin
                n_errors++; $display("FAIL seq_pop%0d: got pc %h inst %h expected pc %h inst 00000013", k, pcs[k], insts[k], 32'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pcs [5];
        int nreq = 0, got = 0;
        bit prev;
        do_reset();
        repeat (30) begin
            prev = bus.mem_req_valid;
            cycle();
            if (!prev && bus.mem_req_valid) nreq++;
        end
        n_checks++; if (nreq != 4) begin n_errors++; $display("FAIL bp_requests: got %0d expected 4", nreq); end
        n_checks++; if (bus.mem_req_valid !== 1'b0 || bus.fetch_ready !== 1'b1) begin n_errors++; $display("FAIL bp_full: got valid %b fr %b expected 0 1", bus.mem_req_valid, bus.fetch_ready); end
        bus.issue_ready = 1'b1;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (bus.fetch_ready) begin pcs[got] = bus.pc; got++; end
            cycle();
        end
        n_checks++; if (got != 5) begin n_errors++; $display("FAIL bp_resume: got %0d pops expected 5", got); end
        for (int k = 0; k < got; k++) begin
            n_checks++; if (pcs[k] !== 32'(4 * k)) begin n_errors++; $display("FAIL bp_pop%0d: got %h expected %h", k, pcs[k], 32'(4 * k)); end
        end
    endtask

    task automatic test_jal();
        logic [31:0] addrs [4];
        logic [31:0] pcs [4];
        logic [31:0] insts [4];
        logic [31:0] exp_addr [4];
        int nreq = 0, got = 0;
        bit prev;
        exp_addr[0] = 32'h0; exp_addr[1] = 32'h4; exp_addr[2] = 32'h8; exp_addr[3] = 32'h18;
        do_reset();
        prog[32'h8] = 32'h0100_006F;
        for (int c = 0; c < 40 && nreq < 4; c++) begin
            prev = bus.mem_req_valid;
            cycle();
            if (!prev && bus.mem_req_valid) begin addrs[nreq] = bus.mem_req_addr; nreq++; end
        end
        n_checks++; if (nreq != 4) begin n_errors++; $display("FAIL jal_reqs: got %0d expected 4", nreq); end
        for (int k = 0; k < nreq; k++) begin
            n_checks++; if (addrs[k] !== exp_addr[k]) begin n_errors++; $display("FAIL jal_req%0d: got %h expected %h", k, addrs[k], exp_addr[k]); end
        end
        bus.issue_ready = 1'b1;
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (bus.fetch_ready) begin pcs[got] = bus.pc; insts[got] = bus.inst; got++; end
            cycle();
        end
        n_checks++; if (got != 4) begin n_errors++; $display("FAIL jal_pops: got %0d expected 4", got); end
        for (int k = 0; k < got; k++) begin
            n_checks++; if (pcs[k] !== exp_addr[k]) begin n_errors++; $display("FAIL jal_pop%0d: got %h expected %h", k, pcs[k], exp_addr[k]); end
        end
        n_checks++; if (got > 2 && insts[2] !== 32'h0100_006F) begin n_errors++; $display("FAIL jal_word: got %h expected 0100006f", insts[2]); end
    endtask

    task automatic test_flush_wait();
        do_reset();
        lat = 2;
        cycle();
        n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0) begin n_errors++; $display("FAIL fw_req: got %b@%h expected 1@0", bus.mem_req_valid, bus.mem_req_addr); end
        flush_in = 1'b1; flush_pc = 32'h100;
        cycle();
        flush_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0 || bus.fetch_ready !== 1'b0) begin
                n_errors++; $display("FAIL fw_drop%0d: got valid %b addr %h fr %b expected 1 0 0", k, bus.mem_req_valid, bus.mem_req_addr, bus.fetch_ready);
            end
            cycle();
        end
        n_checks++; if (bus.fetch_ready !== 1'b0 || bus.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL fw_stale: got fr %b valid %b expected 0 0", bus.fetch_ready, bus.mem_req_valid); end
        lat = 0;
        cycle();
        n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h100 || bus.fetch_ready !== 1'b0) begin n_errors++; $display("FAIL fw_redirect: got %b@%h fr %b expected 1@100 fr 0", bus.mem_req_valid, bus.mem_req_addr, bus.fetch_ready); end
        cycle();
        n_checks++; if (bus.fetch_ready !== 1'b1 || bus.pc !== 32'h100 || bus.inst !== 32'h13) begin n_errors++; $display("FAIL fw_arrive: got fr %b pc %h inst %h expected 1 100 00000013", bus.fetch_ready, bus.pc, bus.inst); end
    endtask

    task automatic test_same_cycle();
        logic [97:0] snap;
        do_reset();
        repeat (3) cycle();
        n_checks++; if (bus.fetch_ready !== 1'b1 || bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h4) begin n_errors++; $display("FAIL sc_setup: got fr %b valid %b addr %h expected 1 1 4", bus.fetch_ready, bus.mem_req_valid, bus.mem_req_addr); end
        flush_in = 1'b1; flush_pc = 32'h200; bus.issue_ready = 1'b1;
        cycle();
        flush_in = 1'b0; bus.issue_ready = 1'b0;
        n_checks++; if (bus.fetch_ready !== 1'b0 || bus.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL sc_flush: got fr %b valid %b expected 0 0", bus.fetch_ready, bus.mem_req_valid); end
        cycle();
        n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h200) begin n_errors++; $display("FAIL sc_redirect: got %b@%h expected 1@200", bus.mem_req_valid, bus.mem_req_addr); end
        cycle(); cycle();
        n_checks++; if (bus.fetch_ready !== 1'b1 || bus.pc !== 32'h200 || bus.mem_req_addr !== 32'h204) begin n_errors++; $display("FAIL sc_refill: got fr %b pc %h addr %h expected 1 200 204", bus.fetch_ready, bus.pc, bus.mem_req_addr); end
        snap = {bus.fetch_ready, bus.inst, bus.pc, bus.mem_req_valid, bus.mem_req_addr};
        rdy_in = 1'b0; bus.issue_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_checks++;
            if ({bus.fetch_ready, bus.inst, bus.pc, bus.mem_req_valid, bus.mem_req_addr} !== snap) begin
                n_errors++; $display("FAIL sc_freeze%0d: got %h expected %h", k, {bus.fetch_ready, bus.inst, bus.pc, bus.mem_req_valid, bus.mem_req_addr}, snap);
            end
        end
        rdy_in = 1'b1; bus.issue_ready = 1'b0;
        cycle();
        n_checks++; if (bus.fetch_ready !== 1'b1 || bus.pc !== 32'h200 || bus.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL sc_thaw: got fr %b pc %h valid %b expected 1 200 0", bus.fetch_ready, bus.pc, bus.mem_req_valid); end
    endtask

    task automatic test_random();
        logic [31:0] fp;
        do_reset();
        rand_mode = 1'b1;
        for (int i = 0; i < 800; i++) begin
            rdy_in          = ($urandom_range(0, 9) != 0);
            bus.issue_ready = 1'($urandom_range(0, 1));
            flush_in        = ($urandom_range(0, 19) == 0);
            fp = $urandom; fp[1:0] = 2'b00; flush_pc = fp;
            if ($urandom_range(0, 15) == 0) lat = $urandom_range(0, 3);
            cycle();
            n_checks++; if (bus.fetch_ready !== 1'(mq.size() != 0)) begin n_errors++; $display("FAIL rnd_fr@%0d: got %b expected %b", i, bus.fetch_ready, mq.size() != 0); end
            if (mq.size() != 0) begin
                n_checks++; if ({bus.inst, bus.pc} !== mq[0]) begin n_errors++; $display("FAIL rnd_head@%0d: got %h/%h expected %h", i, bus.inst, bus.pc, mq[0]); end
            end
            n_checks++; if (bus.mem_req_valid !== m_req) begin n_errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", i, bus.mem_req_valid, m_req); end
            n_checks++; if (bus.mem_req_addr !== m_addr) begin n_errors++; $display("FAIL rnd_addr@%0d: got %h expected %h", i, bus.mem_req_addr, m_addr); end
        end
    endtask

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; flush_pc = 32'h0;
        bus.issue_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 32'h0;
        @(negedge clk_in);
        test_reset();
        test_sequential();
        test_backpressure();
        test_jal();
        test_flush_wait();
        test_same_cycle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
